// File: rtl/img_bus_arb.sv
// img_bus_arb: two-master round-robin arbiter for the shared image memory bus.
// Master 0 is the image-processing controller, master 1 the host/video port.
// Both use the cs_n/we/ack handshake: cs_n held low until a one-cycle ack.
// The granted master's request is forwarded combinationally to the slave and
// the slave ack/read data are routed back in the same cycle.
// Optional feature macro: IMG_BUS_ARB_TIMEOUT_EN (aborts a granted access with
// ack+err after TIMEOUT cycles without a slave ack).
module img_bus_arb #(
  parameter int AW      = 20,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cs_n,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_cs_n,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          s_cs_n,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack_i,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT0    = 2'd1,
    GNT1    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // TIMEOUT is only meaningful as an 8-bit count of 1..255.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("img_bus_arb: TIMEOUT must be in 1..255");
  end

  state_t r_state;
  state_t w_next;
  logic   r_last;      // most recently granted master (1 after reset => m0 wins first tie)

  logic   w_gnt;       // a master currently owns the bus
  logic   w_sel_cs_n;  // cs_n of the granted master
  logic   w_hit;       // real slave ack for a still-requesting granted master
  logic   w_to;        // timeout abort this cycle
  logic   w_ack;       // ack to the granted master (real or timeout)
  logic   w_done;      // granted access ends this cycle (ack, timeout or abandon)

  assign w_gnt      = (r_state == GNT0) || (r_state == GNT1);
  assign w_sel_cs_n = (r_state == GNT1) ? m1_cs_n : m0_cs_n;
  assign w_hit      = w_gnt && !w_sel_cs_n && s_ack_i;
  assign w_ack      = w_hit || w_to;
  assign w_done     = w_gnt && (w_sel_cs_n || w_hit || w_to);
  assign busy       = (r_state != IDLE);

`ifdef IMG_BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_to_cnt;

  // Wait counter: zero on entry to a grant, counts grant cycles without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= 8'd0;
    end else if (w_gnt && !w_done) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end else begin
      r_to_cnt <= 8'd0;
    end
  end

  // The real ack wins over a coincident timeout, so s_ack_i blocks the abort.
  assign w_to = w_gnt && !w_sel_cs_n && !s_ack_i && (r_to_cnt == LP_TO_LAST);
`else
  assign w_to = 1'b0;
`endif

  // State register and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_done) begin
        r_last <= (r_state == GNT1);
      end
    end
  end

  // Next-state selection and bus steering; everything idle outside a grant.
  always_comb begin
    w_next   = r_state;
    s_cs_n   = 1'b1;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    case (r_state)
      IDLE: begin
        if (!m0_cs_n && !m1_cs_n) begin
          w_next = r_last ? GNT0 : GNT1;
        end else if (!m0_cs_n) begin
          w_next = GNT0;
        end else if (!m1_cs_n) begin
          w_next = GNT1;
        end
      end
      GNT0: begin
        s_cs_n   = m0_cs_n;
        s_we     = m0_we;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_ack   = w_ack;
        m0_err   = w_to;
        m0_rdata = w_to ? '0 : s_rdata;
        if (w_done) begin
          w_next = RECOVER;
        end
      end
      GNT1: begin
        s_cs_n   = m1_cs_n;
        s_we     = m1_we;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_ack   = w_ack;
        m1_err   = w_to;
        m1_rdata = w_to ? '0 : s_rdata;
        if (w_done) begin
          w_next = RECOVER;
        end
      end
      RECOVER: begin
        // One dead cycle so a master dropping cs_n after its ack is not re-granted.
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_img_bus_arb.sv
// Testbench for img_bus_arb: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the arbitration rules.
// Build with IMG_BUS_ARB_TIMEOUT_EN defined to exercise the timeout feature.
module tb_img_bus_arb;

  localparam int AW = 20;
  localparam int DW = 8;
`ifdef IMG_BUS_ARB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cs_n, m0_we, m0_ack, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_cs_n, m1_we, m1_ack, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          s_cs_n, s_we, s_ack_i, busy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;

  int checks   = 0;
  int failures = 0;

  img_bus_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cs_n(m0_cs_n), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_cs_n(m1_cs_n), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_cs_n(s_cs_n), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack_i(s_ack_i), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cs_n = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_cs_n = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    s_ack_i = 1'b0; s_rdata = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_cs_n = 1'b0;
    m0_addr = 20'h12345;
    rst = 1'b1;
    tick();
    tick();
    settle();
    checks++;
    if ({s_cs_n, busy, m0_ack, m1_ack, m0_err, m1_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=100000", {s_cs_n, busy, m0_ack, m1_ack, m0_err, m1_err});
    end
    checks++;
    if ({s_we, s_addr, s_wdata, m0_rdata, m1_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {s_we, s_addr, s_wdata, m0_rdata, m1_rdata});
    end
    rst = 1'b0;
    settle();
    checks++;
    if (s_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_before_edge s_cs_n=%b exp=1", s_cs_n);
    end
    tick();
    settle();
    checks++;
    if ({s_cs_n, busy, s_addr} !== {1'b0, 1'b1, 20'h12345}) begin
      failures++;
      $display("FAIL reset_first_grant got cs_n=%b busy=%b addr=%h exp 0 1 12345", s_cs_n, busy, s_addr);
    end
    s_ack_i = 1'b1;
    settle();
    checks++;
    if (m0_ack !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_ack m0_ack=%b exp=1", m0_ack);
    end
    tick();
    m0_cs_n = 1'b1;
    s_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    idle_inputs();
    m0_cs_n = 1'b0;
    m0_addr = 20'h00010;
    s_rdata = 8'hA5;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({m0_ack, s_cs_n, s_we, s_addr} !== {1'b0, 1'b0, 1'b0, 20'h00010}) begin
        failures++;
        $display("FAIL read_wait%0d got ack=%b cs_n=%b we=%b addr=%h exp 0 0 0 00010", i, m0_ack, s_cs_n, s_we, s_addr);
      end
      tick();
    end
    s_ack_i = 1'b1;
    settle();
    checks++;
    if ({m0_ack, m0_rdata, m0_err, m1_ack, m1_rdata} !== {1'b1, 8'hA5, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL read_ack got ack=%b rdata=%h err=%b m1_ack=%b m1_rdata=%h exp 1 a5 0 0 00", m0_ack, m0_rdata, m0_err, m1_ack, m1_rdata);
    end
    tick();
    m0_cs_n = 1'b1;
    s_ack_i = 1'b0;
    settle();
    checks++;
    if ({busy, s_cs_n, m0_ack} !== 3'b110) begin
      failures++;
      $display("FAIL read_recover got busy/cs_n/ack=%b exp=110", {busy, s_cs_n, m0_ack});
    end
    tick();
    settle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL read_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_contention();
    logic [1:0]    exp_ack;
    logic [AW-1:0] exp_addr;
    pulse_reset();
    m0_cs_n = 1'b0; m0_addr = 20'h0AAAA;
    m1_cs_n = 1'b0; m1_addr = 20'h05555;
    s_ack_i = 1'b1;
    settle();
    for (int k = 0; k < 12; k++) begin
      exp_ack  = 2'b00;
      exp_addr = '0;
      if (k % 3 == 1) begin
        if ((k / 3) % 2 == 0) begin
          exp_ack = 2'b01; exp_addr = 20'h0AAAA;
        end else begin
          exp_ack = 2'b10; exp_addr = 20'h05555;
        end
      end
      checks++;
      if ({m1_ack, m0_ack, s_addr} !== {exp_ack, exp_addr}) begin
        failures++;
        $display("FAIL contention_cyc%0d got acks=%b addr=%h exp acks=%b addr=%h", k, {m1_ack, m0_ack}, s_addr, exp_ack, exp_addr);
      end
      tick();
      settle();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_abandon();
    pulse_reset();
    m1_cs_n = 1'b0;
    m1_addr = 20'hABCDE;
    tick();
    settle();
    checks++;
    if ({s_cs_n, s_addr} !== {1'b0, 20'hABCDE}) begin
      failures++;
      $display("FAIL abandon_grant1 got cs_n=%b addr=%h exp 0 abcde", s_cs_n, s_addr);
    end
    m0_cs_n = 1'b0;
    m0_addr = 20'h00777;
    m1_cs_n = 1'b1;
    settle();
    checks++;
    if ({m1_ack, m0_ack, s_cs_n} !== 3'b001) begin
      failures++;
      $display("FAIL abandon_noack got m1_ack/m0_ack/cs_n=%b exp=001", {m1_ack, m0_ack, s_cs_n});
    end
    tick();
    settle();
    checks++;
    if ({busy, s_cs_n, m0_ack, m1_ack} !== 4'b1100) begin
      failures++;
      $display("FAIL abandon_recover got=%b exp=1100", {busy, s_cs_n, m0_ack, m1_ack});
    end
    tick();
    settle();
    checks++;
    if ({busy, s_cs_n} !== 2'b01) begin
      failures++;
      $display("FAIL abandon_idle got busy/cs_n=%b exp=01", {busy, s_cs_n});
    end
    tick();
    settle();
    checks++;
    if ({s_cs_n, s_addr} !== {1'b0, 20'h00777}) begin
      failures++;
      $display("FAIL abandon_grant0 got cs_n=%b addr=%h exp 0 00777", s_cs_n, s_addr);
    end
    s_ack_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
`ifdef IMG_BUS_ARB_TIMEOUT_EN
    pulse_reset();
    m0_cs_n = 1'b0;
    m0_addr = 20'h00444;
    s_rdata = 8'h5A;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({m0_ack, m0_err} !== 2'b00) begin
        failures++;
        $display("FAIL timeout_wait%0d got ack/err=%b exp=00", i, {m0_ack, m0_err});
      end
      tick();
    end
    settle();
    checks++;
    if ({m0_ack, m0_err, m0_rdata} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL timeout_abort got ack=%b err=%b rdata=%h exp 1 1 00", m0_ack, m0_err, m0_rdata);
    end
    tick();
    m0_cs_n = 1'b1;
    settle();
    checks++;
    if ({s_cs_n, busy, m0_ack} !== 3'b110) begin
      failures++;
      $display("FAIL timeout_recover got cs_n/busy/ack=%b exp=110", {s_cs_n, busy, m0_ack});
    end
    tick();
    m0_cs_n = 1'b0;
    tick();
    tick();
    tick();
    tick();
    s_ack_i = 1'b1;
    settle();
    checks++;
    if ({m0_ack, m0_err, m0_rdata} !== {1'b1, 1'b0, 8'h5A}) begin
      failures++;
      $display("FAIL timeout_real_ack_wins got ack=%b err=%b rdata=%h exp 1 0 5a", m0_ack, m0_err, m0_rdata);
    end
    tick();
    idle_inputs();
    tick();
    tick();
`else
    int seen;
    pulse_reset();
    m0_cs_n = 1'b0;
    m0_addr = 20'h00444;
    tick();
    seen = 0;
    repeat (1000) begin
      settle();
      if (m0_ack || m0_err) seen++;
      tick();
    end
    settle();
    checks++;
    if ({seen != 0, s_cs_n, busy, m0_err} !== 4'b0010) begin
      failures++;
      $display("FAIL no_timeout_wait got acks_seen=%0d cs_n=%b busy=%b err=%b exp 0 0 1 0", seen, s_cs_n, busy, m0_err);
    end
    s_ack_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
`endif
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    m0_cs_n  = 1'b0;
    m0_we    = 1'b1;
    m0_addr  = 20'h0F0F0;
    m0_wdata = 8'h3C;
    tick();
    settle();
    checks++;
    if ({s_cs_n, s_we, s_addr, s_wdata} !== {1'b0, 1'b1, 20'h0F0F0, 8'h3C}) begin
      failures++;
      $display("FAIL midrst_grant got cs_n=%b we=%b addr=%h wdata=%h exp 0 1 0f0f0 3c", s_cs_n, s_we, s_addr, s_wdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if ({s_cs_n, busy, m0_ack, m0_err} !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_killed got cs_n/busy/ack/err=%b exp=1000", {s_cs_n, busy, m0_ack, m0_err});
    end
    idle_inputs();
    tick();
    tick();
  endtask

  // Randomized traffic against a reference model: who owns the bus, whether the
  // dead cycle after an access is pending, who was served last, and how long the
  // current owner has waited.
  task automatic test_random();
    int            owner, wait_cyc, last;
    bit            rec;
    bit            req0, req1, ack0, ack1;
    logic          cs;
    logic [50:0]   act, exp;
    logic          e_scs, e_swe, e_busy;
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_swdata, e_rd0, e_rd1;
    logic [1:0]    e_ack, e_err;
    owner = -1; wait_cyc = 0; last = 1; rec = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      settle();
      e_scs = 1'b1; e_swe = 1'b0; e_saddr = '0; e_swdata = '0;
      e_rd0 = '0; e_rd1 = '0; e_ack = 2'b00; e_err = 2'b00;
      e_busy = (owner >= 0) || rec;
      cs = 1'b1;
      if (owner >= 0) begin
        cs       = (owner == 1) ? m1_cs_n : m0_cs_n;
        e_scs    = cs;
        e_swe    = (owner == 1) ? m1_we : m0_we;
        e_saddr  = (owner == 1) ? m1_addr : m0_addr;
        e_swdata = (owner == 1) ? m1_wdata : m0_wdata;
        if (owner == 1) e_rd1 = s_rdata; else e_rd0 = s_rdata;
        if (!cs && s_ack_i) begin
          e_ack[owner] = 1'b1;
        end else if (!cs && TO_EN && wait_cyc == TO - 1) begin
          e_ack[owner] = 1'b1;
          e_err[owner] = 1'b1;
          e_rd0 = '0; e_rd1 = '0;
        end
      end
      exp = {e_scs, e_swe, e_saddr, e_swdata, e_ack[0], e_ack[1], e_err[0], e_err[1], e_rd0, e_rd1, e_busy};
      act = {s_cs_n, s_we, s_addr, s_wdata, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata, busy};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL random_cyc%0d got=%h exp=%h", n, act, exp);
      end
      ack0 = e_ack[0];
      ack1 = e_ack[1];
      // Model advance at the clock edge.
      if (rst) begin
        owner = -1; rec = 1'b0; last = 1; wait_cyc = 0;
      end else if (owner >= 0) begin
        if (cs || e_ack[owner]) begin
          last = owner; owner = -1; rec = 1'b1; wait_cyc = 0;
        end else begin
          wait_cyc++;
        end
      end else if (rec) begin
        rec = 1'b0;
      end else begin
        if (!m0_cs_n && !m1_cs_n) owner = 1 - last;
        else if (!m0_cs_n)        owner = 0;
        else if (!m1_cs_n)        owner = 1;
        wait_cyc = 0;
      end
      tick();
      // Master and slave behaviour for the next cycle.
      if (ack0 || (req0 && $urandom_range(0, 24) == 0)) begin
        req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1;
        m0_we = 1'($urandom); m0_addr = 20'($urandom); m0_wdata = 8'($urandom);
      end
      if (ack1 || (req1 && $urandom_range(0, 24) == 0)) begin
        req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1;
        m1_we = 1'($urandom); m1_addr = 20'($urandom); m1_wdata = 8'($urandom);
      end
      m0_cs_n = ~req0;
      m1_cs_n = ~req1;
      s_ack_i = ($urandom_range(0, 3) == 0);
      s_rdata = 8'($urandom);
      rst     = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_abandon();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_bus_arb.md
# img_bus_arb

Two-master arbiter sharing the single image memory bus between the image-processing controller (master 0) and the host/video-input port (master 1). Each master uses the team's `cs_n`/`we`/`ack` handshake: hold chip-select low until a one-cycle ack. The arbiter grants one master at a time with round-robin fairness. It forwards the granted master's request to the memory slave and routes ack and read data back.

## Interface
Parameters:
- `AW`, 20: address width.
- `DW`, 8: data width.
- `TIMEOUT`, 255: cycles a granted access may wait for `s_ack_i` (used only with `IMG_BUS_ARB_TIMEOUT_EN`); legal range 1..255.

Ports:
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `m0_cs_n`, `m1_cs_n` input 1: request, active low, held until ack.
- `m0_we`, `m1_we` input 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` input AW: access address.
- `m0_wdata`, `m1_wdata` input DW: write data.
- `m0_ack`, `m1_ack` output 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` output DW: read data, valid while the matching ack is 1.
- `m0_err`, `m1_err` output 1: high with ack when the access was aborted by timeout.
- `s_cs_n` output 1: slave chip-select, active low.
- `s_we` output 1: slave write enable.
- `s_addr` output AW: slave address.
- `s_wdata` output DW: slave write data.
- `s_rdata` input DW: slave read data.
- `s_ack_i` input 1: slave ack.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, GNT0, GNT1, RECOVER; 2-bit encoding.
- `last` flag records the most recently granted master; its reset value is 1, so master 0 wins the first tie.
- IDLE:
  - Exactly one `mX_cs_n == 0`: go to GNTX.
  - Both requesting: grant the master != `last`.
  - Neither requesting: stay in IDLE.
- GNTx, slave outputs:
  - `s_cs_n`, `s_we`, `s_addr` and `s_wdata` are combinational copies of master x.
  - Master x's `rdata` = `s_rdata`; the other master's `rdata` = 0.
- GNTx transitions:
  - On `s_ack_i == 1`: `mx_ack = 1` in the same cycle (combinational pass-through), `last <= x`, next state RECOVER.
  - Master x raises `cs_n` before any ack (abandon): no ack, `last <= x`, next state RECOVER.
- RECOVER:
  - Lasts exactly one cycle, then IDLE; requests are ignored.
  - Guarantees that a master which deasserts `cs_n` one cycle after ack is never re-granted on a stale request.
- Outside GNTx:
  - `s_cs_n = 1`, `s_we = 0`, `s_addr = 0`, `s_wdata = 0`.
  - All `mX_ack`, `mX_err` and `mX_rdata` = 0.
  - A stray `s_ack_i` is ignored.
- The non-granted master sees no ack and simply keeps waiting.

## Timing
- Reset values: state IDLE, `last = 1`, timeout counter 0.
- Reset output levels: `s_cs_n = 1`, `s_we = 0`, `s_addr`/`s_wdata` = 0, all acks, errs and rdatas 0, `busy = 0`.
- Grant latency: a request sampled low at edge N in IDLE is visible on `s_cs_n` after edge N (state GNTx during cycle N+1).
- Ack has zero added latency: `mX_ack` is asserted in the same cycle as `s_ack_i`.
- Minimum access: 1 IDLE + 1 GNT + 1 RECOVER cycle, i.e. 3 cycles between back-to-back grants.
- Two continuously requesting masters alternate strictly: 0, 1, 0, 1…
- `rst` asserted mid-access:
  - Next edge forces IDLE and deasserts `s_cs_n`.
  - No ack is generated for the killed access.

## Configuration
`IMG_BUS_ARB_TIMEOUT_EN`:
- Defined:
  - An 8-bit counter clears on entry to GNTx and increments each GNTx cycle without `s_ack_i`.
  - When it reaches `TIMEOUT`, that cycle drives `mx_ack = 1` and `mx_err = 1` with `mx_rdata = 0`, then moves to RECOVER. `s_cs_n` returns high with the state change.
  - If `s_ack_i` arrives in that same cycle, the real ack wins and `err = 0`.
- Undefined: no counter is built, `mX_err` is tied to 0, and a granted access waits indefinitely.

## Test plan
- Reset: hold `rst` 2 cycles -> `s_cs_n = 1`, `busy = 0`, all acks 0. Release and request on m0 only -> `s_cs_n` low 1 cycle later, `s_addr = m0_addr`.
- Single read: m0 reads addr 0x00010, slave acks with `s_rdata = 0xA5` after 3 GNT cycles -> `m0_ack = 1` and `m0_rdata = 0xA5` in that cycle. Then RECOVER, then IDLE.
- Contention: both masters request continuously, slave acks every GNT cycle -> grant order 0, 1, 0, 1, with 3-cycle spacing. m1 never receives an ack while m0 is granted.
- Abandon: m1 is granted, then raises `m1_cs_n` before any ack -> no `m1_ack`, next cycle RECOVER. A pending m0 request is granted next.
- Timeout (macro on, `TIMEOUT = 4`): grant m0, slave never acks -> `m0_ack = m0_err = 1` on the 4th GNT0 cycle, then `s_cs_n = 1`. Repeat with `s_ack_i` in that same cycle -> `m0_err = 0`. With the macro off, the access is still waiting after 1000 cycles.
- Mid-access reset: m0 write granted, `rst` pulsed for one cycle -> `s_cs_n = 1` after the edge, no ack, state IDLE.
